butterfly_dit: RTL and testbench

BUTTERFLY_DIT -- requirements
Module: butterfly_dit

---
 rtl/butterfly_dit.sv | 101 ++++++++++
 tb/tb_butterfly_dit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/butterfly_dit.sv
// butterfly_dit: radix-2 DIT butterfly, two multipliers shared over two phases.
// Accept at E0, phase A at E1, phase B at E2, twiddle product at E3, outputs at E4.
module butterfly_dit #(
   parameter int DATA_WIDTH   = 32,
   parameter int FACTOR_WIDTH = 16,
   parameter int FRAC_BITS    = 14,
   parameter int SCALE        = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2*DATA_WIDTH-1:0]   in_x0,
   input  logic [2*DATA_WIDTH-1:0]   in_x1,
   input  logic [2*FACTOR_WIDTH-1:0] w,
   output logic                      out_valid,
   output logic [2*DATA_WIDTH-1:0]   out_x0,
   output logic [2*DATA_WIDTH-1:0]   out_x1
);
   localparam int DW = DATA_WIDTH;
   localparam int FW = FACTOR_WIDTH;
   localparam int PW = DW + FW;
   logic                 rdy_q, va_q, vb_q, vt_q, vs_q, vo_q;
   logic signed [DW-1:0] x0r_q, x0i_q, x1r_q, x1i_q;
   logic signed [FW-1:0] wr_q, wi_q;
   logic signed [DW-1:0] ar_q, ai_q, br_q, bi_q;
   logic signed [DW-1:0] x0br_q, x0bi_q, x0tr_q, x0ti_q, tr_q, ti_q;
   logic [2*DW-1:0]      out_x0_q, out_x1_q;
   logic                 acc;
   logic signed [DW-1:0] ma;
   logic signed [FW-1:0] mb1, mb2;
   logic signed [PW-1:0] p1, p2;
   logic signed [DW-1:0] q1, q2;
   logic signed [DW:0]   s0r_d, s0i_d, s1r_d, s1i_d;
   logic [2*DW-1:0]      out_x0_d, out_x1_d;
   assign in_ready  = rdy_q & ~rst;
   assign acc       = in_valid & in_ready;
   assign out_valid = vo_q;
   assign out_x0    = out_x0_q;
   assign out_x1    = out_x1_q;
   // phase A feeds x1_r (times w_r, w_i); phase B feeds x1_i (times w_i, w_r)
   assign ma  = va_q ? x1r_q : x1i_q;
   assign mb1 = va_q ? wr_q : wi_q;
   assign mb2 = va_q ? wi_q : wr_q;
   assign p1  = ma * mb1;
   assign p2  = ma * mb2;
   assign q1  = p1[DW+FRAC_BITS-1:FRAC_BITS];
   assign q2  = p2[DW+FRAC_BITS-1:FRAC_BITS];
   always_comb begin
      s0r_d    = {x0tr_q[DW-1], x0tr_q} + {tr_q[DW-1], tr_q};
      s0i_d    = {x0ti_q[DW-1], x0ti_q} + {ti_q[DW-1], ti_q};
      s1r_d    = {x0tr_q[DW-1], x0tr_q} - {tr_q[DW-1], tr_q};
      s1i_d    = {x0ti_q[DW-1], x0ti_q} - {ti_q[DW-1], ti_q};
      out_x0_d = SCALE != 0 ? {s0r_d[DW:1], s0i_d[DW:1]} : {s0r_d[DW-1:0], s0i_d[DW-1:0]};
      out_x1_d = SCALE != 0 ? {s1r_d[DW:1], s1i_d[DW:1]} : {s1r_d[DW-1:0], s1i_d[DW-1:0]};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q    <= 1'b1;
         {va_q, vb_q, vt_q, vs_q, vo_q} <= '0;
         {x0r_q, x0i_q, x1r_q, x1i_q, wr_q, wi_q} <= '0;
         {ar_q, ai_q, br_q, bi_q} <= '0;
         {x0br_q, x0bi_q, x0tr_q, x0ti_q, tr_q, ti_q} <= '0;
         out_x0_q <= '0;
         out_x1_q <= '0;
      end else begin
         rdy_q <= ~acc;
         va_q  <= acc;
         vb_q  <= va_q;
         vt_q  <= vb_q;
         vs_q  <= vt_q;
         vo_q  <= vs_q;
         if (acc) begin
            {x0r_q, x0i_q} <= in_x0;
            {x1r_q, x1i_q} <= in_x1;
            {wr_q, wi_q}   <= w;
         end
         if (va_q) begin
            ar_q <= q1;
            ai_q <= q2;
         end
         // x0 leaves the hold register here, before a following accept can overwrite it
         if (vb_q) begin
            br_q   <= q1;
            bi_q   <= q2;
            x0br_q <= x0r_q;
            x0bi_q <= x0i_q;
         end
         if (vt_q) begin
            tr_q   <= ar_q - br_q;
            ti_q   <= ai_q + bi_q;
            x0tr_q <= x0br_q;
            x0ti_q <= x0bi_q;
         end
         if (vs_q) begin
            out_x0_q <= out_x0_d;
            out_x1_q <= out_x1_d;
         end
      end
   end
endmodule

// File: tb/tb_butterfly_dit.sv
// tb_butterfly_dit: random and directed butterflies on an unscaled and a scaled
// instance, checked cycle by cycle against an arithmetic reference model.
module tb_butterfly_dit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_x0 = '0, in_x1 = '0;
   logic [31:0] w = '0;
   logic        in_ready, out_valid, in_ready_s, out_valid_s;
   logic [63:0] out_x0, out_x1, out_x0_s, out_x1_s;
   int          n_cmp = 0, n_err = 0, cyc = 0;
   logic        prev_acc = 1'b0;
   logic [63:0] last0 = '0, last1 = '0, lasts0 = '0, lasts1 = '0;
   typedef struct {int due; logic [63:0] a0, a1, b0, b1;} exp_t;
   exp_t        q[$];

   always #5 clk = ~clk;

   butterfly_dit #(.SCALE(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x0(in_x0), .in_x1(in_x1), .w(w),
      .out_valid(out_valid), .out_x0(out_x0), .out_x1(out_x1));

   butterfly_dit #(.SCALE(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_x0(in_x0), .in_x1(in_x1), .w(w),
      .out_valid(out_valid_s), .out_x0(out_x0_s), .out_x1(out_x1_s));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] cx(input longint r, input longint i);
      return {32'(r), 32'(i)};
   endfunction

   function automatic logic [31:0] cw(input int r, input int i);
      return {16'(r), 16'(i)};
   endfunction

   // floor(a*b / 2^14), wrapped to 32 bits
   function automatic logic [31:0] fmul(input logic signed [31:0] a, input logic signed [15:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return 32'(p >>> 14);
   endfunction

   function automatic logic [31:0] comb(input logic signed [31:0] a, input logic signed [31:0] t,
                                        input bit sub, input bit sc);
      longint s;
      s = sub ? longint'(a) - longint'(t) : longint'(a) + longint'(t);
      if (sc) s = s >>> 1;
      return 32'(s);
   endfunction

   function automatic exp_t model(input logic [63:0] x0, input logic [63:0] x1, input logic [31:0] ww, input int due);
      exp_t e;
      logic signed [31:0] tr, ti;
      tr = fmul(x1[63:32], ww[31:16]) - fmul(x1[31:0], ww[15:0]);
      ti = fmul(x1[63:32], ww[15:0]) + fmul(x1[31:0], ww[31:16]);
      e.due = due;
      e.a0  = {comb(x0[63:32], tr, 0, 0), comb(x0[31:0], ti, 0, 0)};
      e.a1  = {comb(x0[63:32], tr, 1, 0), comb(x0[31:0], ti, 1, 0)};
      e.b0  = {comb(x0[63:32], tr, 0, 1), comb(x0[31:0], ti, 0, 1)};
      e.b1  = {comb(x0[63:32], tr, 1, 1), comb(x0[31:0], ti, 1, 1)};
      return e;
   endfunction

   task automatic cycle(input logic r, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] ww, output logic acc);
      logic ev;
      @(negedge clk);
      ev = q.size() != 0 && q[0].due == cyc;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_valid_s", 64'(out_valid_s), 64'(ev));
      if (ev) begin
         last0  = q[0].a0;
         last1  = q[0].a1;
         lasts0 = q[0].b0;
         lasts1 = q[0].b1;
         void'(q.pop_front());
      end
      chk("out_x0", out_x0, last0);
      chk("out_x1", out_x1, last1);
      chk("out_x0_s", out_x0_s, lasts0);
      chk("out_x1_s", out_x1_s, lasts1);
      rst = r;
      in_valid = v;
      in_x0 = a;
      in_x1 = b;
      w = ww;
      #1;
      chk("in_ready", 64'(in_ready), 64'(!r && !prev_acc));
      chk("in_ready_s", 64'(in_ready_s), 64'(!r && !prev_acc));
      acc = !r && v && !prev_acc;
      if (r) begin
         q.delete();
         {last0, last1, lasts0, lasts1} = '0;
      end else if (acc) q.push_back(model(a, b, ww, cyc + 5));
      prev_acc = acc;
      cyc++;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(0, 0, $urandom, $urandom, $urandom, acc);
   endtask

   task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [31:0] ww);
      logic acc;
      acc = 0;
      for (int i = 0; i < 4 && !acc; i++) cycle(0, 1, a, b, ww, acc);
      if (!acc) chk("send_accept", 64'(acc), 64'd1);
   endtask

   initial begin
      logic acc;
      repeat (2) @(negedge clk);
      cycle(1, 1, cx(1, 2), cx(3, 4), cw(16384, 0), acc);
      cycle(1, 1, cx(1, 2), cx(3, 4), cw(16384, 0), acc);
      idle(2);
      send(cx(100, 0), cx(50, 0), cw(16384, 0));
      idle(5);
      chk("basic_x0", out_x0, cx(150, 0));
      chk("basic_x1", out_x1, cx(50, 0));
      chk("basic_x0_s", out_x0_s, cx(75, 0));
      chk("basic_x1_s", out_x1_s, cx(25, 0));
      send(cx(10, 10), cx(0, 40), cw(0, -16384));
      idle(5);
      chk("imag_x0", out_x0, cx(50, 10));
      chk("imag_x1", out_x1, cx(-30, 10));
      send(cx(0, 0), cx(3, 0), cw(8192, 0));
      idle(5);
      chk("trunc_pos", out_x0, cx(1, 0));
      send(cx(0, 0), cx(-3, 0), cw(8192, 0));
      idle(5);
      chk("trunc_neg", out_x0, cx(-2, 0));
      send(cx(32'h7FFF_FFFF, 0), cx(1, 0), cw(16384, 0));
      idle(5);
      chk("wrap_x0", out_x0, {32'h8000_0000, 32'h0});
      chk("wrap_x0_s", out_x0_s, {32'h4000_0000, 32'h0});
      send(cx(1, 2), cx(300, -7), cw(-5000, 12000));
      send(cx(-9, 4), cx(-1000, 77), cw(16383, -16384));
      send(cx(5, -5), cx(123456, -654321), cw(-32768, 32767));
      idle(6);
      send(cx(11, 22), cx(33, 44), cw(16384, 0));
      idle(1);
      cycle(1, 1, cx(0, 0), cx(0, 0), cw(0, 0), acc);
      idle(8);
      for (int i = 0; i < 400; i++) begin
         logic [63:0] a, b;
         logic [31:0] ww;
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         ww = $urandom;
         if ($urandom_range(0, 9) == 0) a = {32'h7FFF_FFFF, 32'h8000_0000};
         if ($urandom_range(0, 9) == 0) ww = {16'h8000, 16'h7FFF};
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, a, b, ww, acc);
      end
      idle(8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
